// File: rtl/panel_ram_arbiter.sv
// Front-panel bitmap RAM arbiter: video has absolute priority, the fill sequencer
// and the byte loader FIFO share the cycles video leaves free.
module panel_ram_arbiter #(
    parameter int AW          = 15,
    parameter int DEPTH       = 8,
    parameter int CLEAR_WORDS = 32768
) (
    input  logic          clk36m,
    input  logic          reset,
    input  logic          vid_busy,
    input  logic [AW-1:0] vid_addr,
    output logic [31:0]   vid_data,
    input  logic          dl_wr,
    input  logic [AW+1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    output logic          ovf,
    input  logic          clr_req,
    input  logic [3:0]    clr_pixel,
    output logic          clr_busy,
    output logic          clr_done,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] LAST_WORD = (AW+1)'(CLEAR_WORDS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    typedef struct packed {
        logic [AW+1:0] addr;
        logic [7:0]    data;
    } entry_t;

    state_t        state;
    logic [AW:0]   counter;

    entry_t        fifo_mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          clr_issue;
    logic          dl_issue;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = fifo_mem[rd_ptr];

    // Full is judged on the pre-edge count, so a same-edge pop never admits a byte.
    assign push = dl_wr && !full;

    // A pending clr_req takes precedence so queued bytes land after the fill.
    assign clr_issue = (state == CLEAR) && !vid_busy;
    assign dl_issue  = (state == IDLE) && !clr_req && !empty && !vid_busy;
    assign pop       = dl_issue;

    assign dl_wait  = full;
    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);
    assign vid_data = mem_rdata;

    // FIFO storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk36m) begin
        if (push)
            fifo_mem[wr_ptr] <= '{addr: dl_addr, data: dl_data};
    end

    always_ff @(posedge clk36m or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (dl_wr && full)
                ovf <= 1'b1;
        end
    end

    // Fill sequencer; the extra counter bit lets CLEAR_WORDS = 2^AW terminate.
    always_ff @(posedge clk36m or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        counter <= '0;
                    end
                end
                CLEAR: begin
                    if (!vid_busy) begin
                        counter <= counter + (AW+1)'(1);
                        if (counter == LAST_WORD)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port mux: video address passes straight through unless a write is issued.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = vid_addr;
        mem_be    = 4'b0000;
        mem_wdata = 32'h0;
        if (clr_issue) begin
            mem_we    = 1'b1;
            mem_addr  = counter[AW-1:0];
            mem_be    = 4'b1111;
            mem_wdata = {8{clr_pixel}};
        end else if (dl_issue) begin
            mem_we    = 1'b1;
            mem_addr  = head.addr[AW+1:2];
            mem_be    = 4'b0001 << head.addr[1:0];
            mem_wdata = {4{head.data}};
        end
    end

endmodule
